// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes: AND/OR/ADD/SUB/SLL, zero and illegal-op flags.
// Define ALU_BARREL_SHIFT_EN for a single-cycle barrel SLL; by default SLL shifts one bit per cycle.
module alu_exec_unit #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_illegal;

  logic               w_accept;
  logic               w_legal;
  logic               w_start_shift;
  logic               w_shift_last;
  logic [WIDTH-1:0]   w_load_value;
  logic [WIDTH-1:0]   w_shift_value;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_shamt  = b[SHAMT_W-1:0];

  // Value loaded into result at the accept edge (SLL with shamt>0 is finished by the shifter).
  always_comb begin
    w_legal      = 1'b1;
    w_load_value = '0;
    case (operation)
      OP_AND: w_load_value = a & b;
      OP_OR:  w_load_value = a | b;
      OP_ADD: w_load_value = a + b;
      OP_SUB: w_load_value = a - b;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL: w_load_value = a << w_shamt;
`else
      OP_SLL: w_load_value = a;
`endif
      default: begin
        w_legal      = 1'b0;
        w_load_value = '0;
      end
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign w_start_shift = 1'b0;
  assign w_shift_last  = 1'b0;
  assign w_shift_value = '0;
`else
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;

  assign w_start_shift = w_accept && (operation == OP_SLL) && (w_shamt != '0);
  assign w_shift_last  = (r_state == S_SHIFT) && (r_cnt == CNT_ONE);
  assign w_shift_value = {r_acc[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_start_shift) begin
      r_acc <= a;
      r_cnt <= w_shamt;
    end else if (r_state == S_SHIFT) begin
      r_acc <= w_shift_value;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_start_shift ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (w_shift_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_illegal <= !w_legal;
      if (!w_start_shift) begin
        r_result <= w_load_value;
        r_zero   <= (w_load_value == '0);
      end
    end else if (w_shift_last) begin
      r_result <= w_shift_value;
      r_zero   <= (w_shift_value == '0);
    end
  end

  assign result     = r_result;
  assign zero       = r_zero;
  assign illegal_op = r_illegal;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU control decoder, together with two operands.
- Returns the result and a zero flag; the zero flag drives the beq branch decision.
- Uses valid/ready handshakes on input and output so the hazard/stall logic can back-pressure it.
- SLL is executed iteratively, one bit per cycle, giving variable latency; all other ops take one cycle.

Parameters:
- WIDTH, 64, operand/result width in bits (RV64 datapath).
- SHAMT_W, 6, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  operation/operands valid
- in_ready  output  1  unit can accept an operation
- operation  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 SLL
- a  input  WIDTH  operand A (rs1)
- b  input  WIDTH  operand B (rs2/imm); b[SHAMT_W-1:0] is the shift amount for SLL
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  registered (result == 0)
- illegal_op  output  1  registered; operation code was not one of the five listed

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; result=0; zero=0; illegal_op=0; out_valid=0; internal counter=0.
  - in_ready reads 1 after the reset edge.
  - Reset aborts any in-flight operation and discards its result.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE); out_valid = (state==DONE). Both are combinational from state.
- IDLE: acceptance happens on the edge where in_valid && in_ready.
  - AND/OR/ADD/SUB: result <= op(a,b); go to DONE.
  - ADD and SUB wrap modulo 2^WIDTH. No carry or overflow output. Example: 0-1 gives all ones.
  - SLL with shamt==0: result <= a; go to DONE.
  - SLL with shamt>0: acc <= a; cnt <= shamt; go to SHIFT.
  - Illegal code: result <= 0; illegal_op <= 1; go to DONE.
  - zero <= (next result == 0) on every load, including the illegal case (zero=1).
  - illegal_op <= 0 for every legal op.
- SHIFT: on each edge, acc <= acc<<1 and cnt <= cnt-1.
  - On the edge where cnt==1, take the final shift and go to DONE. result and zero update on that edge.
  - in_ready=0 throughout; input is ignored.
- Latency, measured in edges from the accept edge (inclusive) until out_valid=1:
  - 1 for AND/OR/ADD/SUB/illegal and SLL with shamt 0.
  - shamt+1 for SLL with shamt>=1. Maximum is 2^SHAMT_W edges.
- DONE: result, zero and illegal_op hold stable while out_ready==0.
  - On an edge with out_ready==1, go to IDLE. result, zero and illegal_op keep their values, but only out_valid qualifies them.
  - No back-to-back overlap: a new accept requires IDLE, so throughput is at most one op per 2 cycles.
- Input changes while not in IDLE have no effect.
- Operands are sampled only at the accept edge; a and b are not held internally beyond acc/cnt.
- Simultaneous reset and handshake: reset wins.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
  - Defined: SLL is computed combinationally as a << shamt at the accept edge and goes straight to DONE. Latency is 1 for all ops. The SHIFT state and counter are not synthesized.
  - Undefined: iterative shift as described above.
- Interface and all other behaviour are identical in both builds.

Test Plan:
- ADD, a=5, b=7 -> result=12, zero=0, illegal_op=0; out_valid rises 1 edge after accept; in_ready=0 while out_valid=1.
- SUB, a=b=0x1234 -> result=0, zero=1. Then SUB a=0, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF, zero=0.
- AND a=0xF0F0, b=0x0FF0 -> 0x00F0. OR with the same operands -> 0xFFF0.
- SLL a=1, b=3 -> result=8, out_valid after 4 edges (1 edge with ALU_BARREL_SHIFT_EN). SLL a=1, b=63 -> 0x8000_0000_0000_0000 after 64 edges. SLL b=0 -> result=a after 1 edge.
- Back-pressure: hold out_ready=0 for 5 cycles after ADD 5+7 while driving in_valid with SUB -> result stays 12, in_ready=0, SUB not accepted. Release out_ready -> IDLE, then SUB is accepted.
- Illegal op 4'b1111 -> result=0, zero=1, illegal_op=1. Separately, reset=0 during SLL with shamt=40, 10 edges in -> after the reset edge out_valid=0, in_ready=1, result=0, illegal_op=0.
